immediate_encoder: RTL

- Inverse of the CPU immediate extender: packs a 32-bit signed immediate into the scattered I/S/B/J immediate bit fields of a base instruction word.
- Emits complete 32-bit instructions for the program loader and self-test generator.
- Structure: valid/ready input, one encode pipeline register (S1), then an output FIFO.
- Reports, per word, any immediate that does not fit the selected format.

---
 rtl/immediate_encoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/immediate_encoder.sv
// immediate_encoder: packs a signed 32-bit immediate into the I/S/B/J
// immediate fields of a base instruction word. The flow is a valid/ready
// input, one encode register (S1) and an output FIFO of DEPTH entries.
// Each word carries a range-error flag when its immediate does not fit
// the selected format.
// Optional feature macro: ROUNDTRIP_CHECK_EN. When it is defined, an extend
// instance decodes the S1 word again and check_fail latches any mismatch.
module immediate_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_base_instruction,
    input  logic [31:0]              in_immediate,
    input  logic [1:0]               in_immediate_select,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instruction,
    output logic                     out_range_error,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     check_fail
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Encode stage
    logic [31:0] enc_instruction;
    logic        enc_range_error;

    // S1 register
    logic        s1_valid_reg;
    logic [31:0] s1_instruction_reg;
    logic        s1_range_error_reg;

    // FIFO state: each entry holds {range_error, instruction}
    logic [32:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Handshake terms
    logic fifo_pop;
    logic fifo_accept;
    logic fifo_push;
    logic in_accept;

    // A value fits a signed field of width W when bits [31:W-1] are all equal.
    // The fit range is -2^(W-1) .. 2^(W-1)-1.
    logic fits_12;
    logic fits_13;
    logic fits_21;

    assign fits_12 = (&in_immediate[31:11]) | ~(|in_immediate[31:11]);
    assign fits_13 = (&in_immediate[31:12]) | ~(|in_immediate[31:12]);
    assign fits_21 = (&in_immediate[31:20]) | ~(|in_immediate[31:20]);

    // Scatter the immediate into the format's bit positions. All other bits
    // come from the base word. The range flag is computed here as well.
    always_comb begin
        enc_instruction = in_base_instruction;
        enc_range_error = 1'b0;
        case (in_immediate_select)
            2'b00: begin
                enc_instruction[31:20] = in_immediate[11:0];
                enc_range_error        = ~fits_12;
            end
            2'b01: begin
                enc_instruction[31:25] = in_immediate[11:5];
                enc_instruction[11:7]  = in_immediate[4:0];
                enc_range_error        = ~fits_12;
            end
            2'b10: begin
                enc_instruction[31]    = in_immediate[12];
                enc_instruction[30:25] = in_immediate[10:5];
                enc_instruction[11:8]  = in_immediate[4:1];
                enc_instruction[7]     = in_immediate[11];
                enc_range_error        = ~fits_13 | in_immediate[0];
            end
            default: begin
                enc_instruction[31]    = in_immediate[20];
                enc_instruction[30:21] = in_immediate[10:1];
                enc_instruction[20]    = in_immediate[11];
                enc_instruction[19:12] = in_immediate[19:12];
                enc_range_error        = ~fits_21 | in_immediate[0];
            end
        endcase
    end

    // The FIFO can take a word when it has space or is popping this cycle.
    // in_ready depends combinationally on out_ready, and this is intended.
    assign out_valid   = (count_reg != '0);
    assign fifo_pop    = out_valid & out_ready;
    assign fifo_accept = (count_reg < CNT_W'(DEPTH)) | fifo_pop;
    assign fifo_push   = s1_valid_reg & fifo_accept;
    assign in_ready    = ~s1_valid_reg | fifo_accept;
    assign in_accept   = in_valid & in_ready;

    // S1 loads on accept, empties when its word moves into the FIFO,
    // and otherwise holds the word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg       <= 1'b0;
            s1_instruction_reg <= '0;
            s1_range_error_reg <= 1'b0;
        end else if (in_accept) begin
            s1_valid_reg       <= 1'b1;
            s1_instruction_reg <= enc_instruction;
            s1_range_error_reg <= enc_range_error;
        end else if (fifo_push) begin
            s1_valid_reg       <= 1'b0;
        end
    end

    // FIFO storage write. Storage has no reset because validity is tracked
    // by the count and the pointers.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg] <= {s1_range_error_reg, s1_instruction_reg};
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH
    // is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The head word is read combinationally. Outputs are forced to zero
    // while the FIFO is empty.
    assign out_instruction = out_valid ? fifo_mem[rd_ptr_reg][31:0] : 32'd0;
    assign out_range_error = out_valid ? fifo_mem[rd_ptr_reg][32]   : 1'b0;
    assign fifo_count      = count_reg;

`ifdef ROUNDTRIP_CHECK_EN
    logic [31:0] s1_immediate_reg;
    logic [1:0]  s1_select_reg;
    logic [31:0] ext_immediate;
    logic        check_fail_reg;

    // Keep the original immediate and format beside S1 for the round trip.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_immediate_reg <= '0;
            s1_select_reg    <= '0;
        end else if (in_accept) begin
            s1_immediate_reg <= in_immediate;
            s1_select_reg    <= in_immediate_select;
        end
    end

    extend u_extend (
        .instruction      (s1_instruction_reg),
        .immediate_select (s1_select_reg),
        .immediate        (ext_immediate)
    );

    // Latch any in-range word whose decoded immediate differs from the
    // original immediate held beside S1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            check_fail_reg <= 1'b0;
        end else if (fifo_push && !s1_range_error_reg &&
                     (ext_immediate != s1_immediate_reg)) begin
            check_fail_reg <= 1'b1;
        end
    end

    assign check_fail = check_fail_reg;
`else
    assign check_fail = 1'b0;
`endif

endmodule
